// File: rtl/mem_access_unit_pkg.sv
// Shared constants and types for the MEM-stage load/store unit:
// access-size codes, FSM state encoding and byte-lane helpers.
package mem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_ILL  = 2'b11;

    typedef logic [0:0] state_t;

    localparam state_t IDLE   = 1'b0;
    localparam state_t RMW_WR = 1'b1;

    // Byte offset within a word; lane 0 is bits 7:0 (little-endian).
    typedef logic [1:0] lane_t;

    function automatic logic is_misaligned(input logic [1:0] size, input lane_t lane);
        logic misaligned;
        case (size)
            SIZE_HALF: misaligned = lane[0];
            SIZE_WORD: misaligned = (lane != 2'b00);
            default:   misaligned = 1'b0;
        endcase
        return misaligned;
    endfunction

    function automatic logic is_sub_word(input logic [1:0] size);
        return (size == SIZE_BYTE) || (size == SIZE_HALF);
    endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Picks the addressed byte/halfword out of a memory word and sign- or
// zero-extends it to 32 bits; word loads pass straight through.
module load_extend
    import mem_pkg::*;
(
    input  logic [31:0] read_data,
    input  lane_t       lane,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] rdata
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Halfword lane is chosen by lane[1] only; lane[0] is known to be 0 here.
    always_comb begin
        byte_sel = read_data[{lane, 3'b000} +: 8];
        half_sel = read_data[{lane[1], 4'b0000} +: 16];
        rdata    = '0;
        case (size)
            SIZE_BYTE: rdata = is_unsigned ? {24'h000000, byte_sel}
                                           : {{24{byte_sel[7]}}, byte_sel};
            SIZE_HALF: rdata = is_unsigned ? {16'h0000, half_sel}
                                           : {{16{half_sel[15]}}, half_sel};
            SIZE_WORD: rdata = read_data;
            default:   rdata = '0;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit in front of a word-only DataMemory. Adds byte and
// halfword accesses; sub-word stores are a two-cycle read-modify-write.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_read,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  stall,
    output logic                  access_err,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] writeData,
    output logic                  MemRead,
    output logic                  MemWrite,
    input  logic [DATA_WIDTH-1:0] readData
);

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] merge_q, merge_d;
    logic [DATA_WIDTH-1:0] load_data;
    lane_t                 lane;
    logic                  active;
    logic                  illegal;
    logic                  sub_store;

    assign lane    = req_addr[1:0];
    assign address = {req_addr[ADDR_WIDTH-1:2], 2'b00};

    load_extend u_load_extend (
        .read_data   (readData),
        .lane        (lane),
        .size        (req_size),
        .is_unsigned (req_unsigned),
        .rdata       (load_data)
    );

    always_comb begin
        active    = req_valid && (req_read || req_write);
        illegal   = (req_read && req_write) || (req_size == SIZE_ILL)
                    || is_misaligned(req_size, lane);
        sub_store = active && !illegal && req_write && is_sub_word(req_size);
    end

    // The merge word is captured in the IDLE cycle of a sub-word store and
    // written back unchanged in RMW_WR.
    always_comb begin
        merge_d = merge_q;
        if (state_q == IDLE && sub_store) begin
            merge_d = readData;
            if (req_size == SIZE_BYTE) begin
                merge_d[{lane, 3'b000} +: 8] = req_wdata[7:0];
            end else begin
                merge_d[{lane[1], 4'b0000} +: 16] = req_wdata[15:0];
            end
        end
    end

    always_comb begin
        state_d    = IDLE;
        rdata      = '0;
        stall      = 1'b0;
        access_err = 1'b0;
        writeData  = '0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        if (rst) begin
            state_d = IDLE;
        end else if (state_q == RMW_WR) begin
            MemWrite  = 1'b1;
            writeData = merge_q;
        end else if (active) begin
            if (illegal) begin
                access_err = 1'b1;
            end else if (req_read) begin
                MemRead = 1'b1;
                rdata   = load_data;
            end else if (req_size == SIZE_WORD) begin
                MemWrite  = 1'b1;
                writeData = req_wdata;
            end else begin
                MemRead = 1'b1;
                stall   = 1'b1;
                state_d = RMW_WR;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            merge_q <= '0;
        end else begin
            state_q <= state_d;
            merge_q <= merge_d;
        end
    end

endmodule
